regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the RISC-V core, the pipelined successor to the single-write, two-read file. It provides NUM_RD combinational read ports and NUM_WR write ports, with x0 hardwired to zero and optional write-to-read bypass. A per-register scoreboard tracks destinations reserved at issue and not yet written back, so the issue stage can stall on read-after-write hazards.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDRESS_WIDTH, 5, register address bits
- NUM_REGS, 32, register count; must be ≤ 2^ADDRESS_WIDTH
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 2, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDRESS_WIDTH  packed read addresses; port k at [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data
- rd_busy  out  NUM_RD  addressed register has a pending write
- wr_en  in  NUM_WR  per-port write enable
- wr_dest  in  NUM_WR*ADDRESS_WIDTH  packed write addresses
- wr_data  in  NUM_WR*DATA_WIDTH  packed write data
- rsv_en  in  1  reserve rsv_dest (instruction issued)
- rsv_dest  in  ADDRESS_WIDTH  register to mark pending
- flush  in  1  synchronous clear of all pending marks
- busy_count  out  $clog2(NUM_REGS+1)  number of registers currently pending

## Operation
- State per register: data[DATA_WIDTH] and busy bit.
- While rst = 0 (asynchronous assertion): all data = 0, all busy = 0, busy_count = 0. Consequently every rd_data = 0 and every rd_busy = 0. Writes, reservations and flush are ignored.
- Write:
  - On a rising edge, data[wr_dest[p]] ← wr_data[p] for each p with wr_en[p] = 1, and busy[wr_dest[p]] is cleared.
  - Two ports writing the same address in one cycle: the higher port index wins the data.
  - Addresses ≥ NUM_REGS are ignored.
- Reserve: on a rising edge with rsv_en = 1, busy[rsv_dest] ← 1.
- Same-edge priority for one register: reserve > write-clear > flush. Data is still updated by the write.
- Flush: clears every busy bit not being reserved that cycle.
- ZERO_REG = 1: a write or reserve to register 0 has no effect. Register 0 reads 0 and its rd_busy is 0.
- Read (combinational):
  - rd_data[k] = data[rd_addr[k]].
  - If BYPASS = 1 and some enabled write port targets rd_addr[k] this cycle, rd_data[k] returns that port's wr_data (highest index wins) and rd_busy[k] = 0.
  - Otherwise rd_busy[k] = busy[rd_addr[k]].
  - rd_addr ≥ NUM_REGS: rd_data = 0, rd_busy = 0.
- busy_count:
  - Registered; equals the popcount of the busy vector after each edge.
  - Maintained incrementally: +1 for a reserve of a non-busy register, −1 per distinct busy register cleared, set to the popcount of surviving reservations on flush.
  - Never exceeds NUM_REGS (or NUM_REGS−1 with ZERO_REG = 1).

## Timing
- Write latency: data visible on rd_data one cycle after the edge when BYPASS = 0, and in the same cycle when BYPASS = 1.
- Reserve latency: rd_busy rises the cycle after the rsv_en edge.
- Writeback clears busy for the following cycle, or immediately via bypass.
- Reset release: the first state update occurs on the first rising edge with rst = 1.
- Reset asserted mid-cycle: all outputs go to 0 without waiting for a clock edge.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst = 0 between edges → rd_data for x5 = 0 immediately, busy_count = 0.
- Dual write, same dest: port0 writes 0x11 and port1 writes 0x22 to x7 → next cycle x7 reads 0x22. With BYPASS = 1, the same-cycle read also returns 0x22.
- x0: write 0xFFFFFFFF and reserve x0 → x0 reads 0, rd_busy = 0, busy_count unchanged.
- Scoreboard: reserve x3, x4, x5 on consecutive cycles → busy_count = 1, 2, 3. Write x4 → busy_count = 2, rd_busy(x4) = 0. Reserve x3 again → count stays 2.
- Reserve and write x9 on the same edge → x9 data updated, busy = 1, busy_count +1.
- Flush and reserve x10 on the same edge with x3/x5 pending → only x10 is busy, busy_count = 1.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Reads are combinational with optional same-cycle write forwarding. The
// busy vector and busy_count let the issue stage stall on RAW hazards.
module regfile_mp #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2,
  parameter bit BYPASS        = 1'b1,
  parameter bit ZERO_REG      = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                 rd_busy,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   wr_dest,
  input  logic [NUM_WR*DATA_WIDTH-1:0]      wr_data,
  input  logic                              rsv_en,
  input  logic [ADDRESS_WIDTH-1:0]          rsv_dest,
  input  logic                              flush,
  output logic [$clog2(NUM_REGS+1)-1:0]     busy_count
);

  localparam int CW = $clog2(NUM_REGS + 1);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0]       mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] rsv_hit;
  logic [NUM_REGS-1:0] wr_hit;
  logic [CW-1:0]       clr_count;
  logic [CW-1:0]       count_next;
  logic                rsv_valid;

  // An address takes part in writes, reservations and reads only if it maps
  // to a real register and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  // Scoreboard next state: reserve beats write-clear beats flush per register,
  // and busy_count is adjusted by the same events rather than re-counted.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value held over from a previous evaluation (no latches).
    rsv_valid  = rsv_en && addr_ok(rsv_dest);
    rsv_hit    = '0;
    wr_hit     = '0;
    clr_count  = '0;
    busy_next  = busy;
    count_next = busy_count;
    if (rsv_valid) rsv_hit[rsv_dest] = 1'b1;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && addr_ok(wr_dest[p*AW +: AW])) wr_hit[wr_dest[p*AW +: AW]] = 1'b1;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rsv_hit[r])               busy_next[r] = 1'b1;
      else if (wr_hit[r] || flush)  busy_next[r] = 1'b0;
      // wr_hit is one bit per register, so two ports hitting the same busy
      // register only count one release.
      if (busy[r] && wr_hit[r] && !rsv_hit[r]) clr_count = clr_count + CW'(1);
    end
    if (flush) count_next = CW'(rsv_valid);
    else       count_next = busy_count + CW'(rsv_valid && !busy[rsv_dest]) - clr_count;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop in
    // the design samples the pre-edge values regardless of block ordering.
    if (!rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // Register storage; later ports overwrite earlier ones on the same address.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the array is built from resettable flops, not a RAM macro, because
    // every register must read zero while reset is held.
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && addr_ok(wr_dest[p*AW +: AW])) mem[wr_dest[p*AW +: AW]] <= wr_data[p*DW +: DW];
      end
    end
  end

  // Combinational read ports with optional forwarding of this cycle's writes.
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (addr_ok(ra)) begin
        rd_data[k*DW +: DW] = mem[ra];
        rd_busy[k]          = busy[ra];
        // Forwarding is suppressed in reset so outputs stay at zero.
        if (BYPASS && rst) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_dest[p*AW +: AW] == ra)) begin
              rd_data[k*DW +: DW] = wr_data[p*DW +: DW];
              rd_busy[k]          = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic compared against an array-based model of the register file.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int CW  = $clog2(NR + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_dest;
  logic [NWR*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_dest;
  logic              flush;
  logic [CW-1:0]     busy_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain arrays of register contents and pending flags.
  logic [DW-1:0] m_data [NR];
  bit            m_busy [NR];

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR),
    .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_dest(rsv_dest), .flush(flush),
    .busy_count(busy_count)
  );

  task automatic idle();
    wr_en = '0; wr_dest = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_dest = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_dest[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_data[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Advance one clock edge and apply the architectural rules to the model:
  // writes store data and release, flush releases everything, a reservation
  // then sets its register, so it overrides both.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_dest[p*AW +: AW] != 0) begin
          m_data[wr_dest[p*AW +: AW]] = wr_data[p*DW +: DW];
          m_busy[wr_dest[p*AW +: AW]] = 1'b0;
        end
      end
      if (flush) for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
      if (rsv_en && rsv_dest != 0) m_busy[rsv_dest] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [DW-1:0] exp_data(input int k);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = rd_addr[k*AW +: AW];
    d = (a == 0) ? '0 : m_data[a];
    for (int p = 0; p < NWR; p++)
      if (a != 0 && wr_en[p] && wr_dest[p*AW +: AW] == a) d = wr_data[p*DW +: DW];
    return d;
  endfunction

  function automatic logic exp_busy(input int k);
    logic [AW-1:0] a;
    logic b;
    a = rd_addr[k*AW +: AW];
    b = (a == 0) ? 1'b0 : m_busy[a];
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_dest[p*AW +: AW] == a) b = 1'b0;
    return b;
  endfunction

  function automatic logic [CW-1:0] exp_count();
    int n;
    n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
    return CW'(n);
  endfunction

  task automatic test_reset();
    idle();
    rd_addr = '0;
    #1 rst = 1'b0;
    set_wr(0, 5, 32'hCAFE_F00D);
    set_wr(1, 5, 32'h1234_5678);
    set_rd(0, 5);
    #2;
    vectors++;
    if (rd_data[DW-1:0] !== '0) begin
      miscompares++; $display("FAIL reset_rd_data: got %h want 0", rd_data[DW-1:0]);
    end
    vectors++;
    if (rd_busy !== '0 || busy_count !== '0) begin
      miscompares++; $display("FAIL reset_busy: rd_busy %b count %0d want 0/0", rd_busy, busy_count);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    idle();
    set_wr(0, 5, 32'hDEAD_BEEF);
    rsv_en = 1'b1; rsv_dest = 5'd6;
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== 32'hDEAD_BEEF || busy_count !== CW'(1)) begin
      miscompares++; $display("FAIL write_x5: got %h count %0d want deadbeef count 1", rd_data[DW-1:0], busy_count);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== '0 || busy_count !== '0) begin
      miscompares++; $display("FAIL async_reset: got %h count %0d want 0 count 0", rd_data[DW-1:0], busy_count);
    end
    #1 rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_dual_write();
    idle();
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    set_rd(0, 7); set_rd(1, 7);
    #2;
    for (int k = 0; k < NRD; k++) begin
      vectors++;
      if (rd_data[k*DW +: DW] !== 32'h22 || rd_busy[k] !== 1'b0) begin
        miscompares++; $display("FAIL dual_bypass port%0d: got %h busy %b want 22 busy 0", k, rd_data[k*DW +: DW], rd_busy[k]);
      end
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== 32'h22) begin
      miscompares++; $display("FAIL dual_registered: got %h want 22", rd_data[DW-1:0]);
    end
  endtask

  task automatic test_x0();
    idle();
    set_wr(0, 0, 32'hFFFF_FFFF);
    rsv_en = 1'b1; rsv_dest = '0;
    set_rd(0, 0);
    #2;
    vectors++;
    if (rd_data[DW-1:0] !== '0 || rd_busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL x0_same_cycle: got %h busy %b want 0 busy 0", rd_data[DW-1:0], rd_busy[0]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== '0 || rd_busy[0] !== 1'b0 || busy_count !== '0) begin
      miscompares++; $display("FAIL x0_after: got %h busy %b count %0d want 0 0 0", rd_data[DW-1:0], rd_busy[0], busy_count);
    end
  endtask

  task automatic test_scoreboard();
    for (int i = 3; i <= 5; i++) begin
      idle();
      rsv_en = 1'b1; rsv_dest = AW'(i);
      tick();
      vectors++;
      if (busy_count !== CW'(i - 2)) begin
        miscompares++; $display("FAIL rsv_count x%0d: got %0d want %0d", i, busy_count, i - 2);
      end
    end
    idle();
    set_wr(0, 4, 32'h0404_0404);
    set_rd(0, 4); set_rd(1, 3);
    #2;
    vectors++;
    if (rd_busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL wb_bypass_busy: got %b want 0", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (busy_count !== CW'(2) || rd_busy !== 2'b10) begin
      miscompares++; $display("FAIL wb_release: count %0d rd_busy %b want 2 10", busy_count, rd_busy);
    end
    rsv_en = 1'b1; rsv_dest = 5'd3;
    tick();
    idle();
    vectors++;
    if (busy_count !== CW'(2)) begin
      miscompares++; $display("FAIL rsv_again: got %0d want 2", busy_count);
    end
  endtask

  task automatic test_rsv_and_write();
    idle();
    set_wr(1, 9, 32'h9999_0009);
    rsv_en = 1'b1; rsv_dest = 5'd9;
    tick();
    idle();
    set_rd(0, 9);
    #1;
    vectors++;
    if (rd_data[DW-1:0] !== 32'h9999_0009 || rd_busy[0] !== 1'b1 || busy_count !== CW'(3)) begin
      miscompares++; $display("FAIL rsv_write_x9: got %h busy %b count %0d want 99990009 1 3", rd_data[DW-1:0], rd_busy[0], busy_count);
    end
  endtask

  task automatic test_flush();
    idle();
    flush = 1'b1;
    rsv_en = 1'b1; rsv_dest = 5'd10;
    tick();
    idle();
    set_rd(0, 10); set_rd(1, 3);
    #1;
    vectors++;
    if (rd_busy !== 2'b01 || busy_count !== CW'(1)) begin
      miscompares++; $display("FAIL flush_rsv: rd_busy %b count %0d want 01 1", rd_busy, busy_count);
    end
    flush = 1'b1;
    tick();
    idle();
    vectors++;
    if (busy_count !== '0) begin
      miscompares++; $display("FAIL flush_all: got %0d want 0", busy_count);
    end
  endtask

  // Random traffic on a narrow address range so ports collide often.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, int'($urandom_range(0, 15)), DW'($urandom));
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_dest = AW'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NRD; k++) set_rd(k, int'($urandom_range(0, 15)));
      #2;
      for (int k = 0; k < NRD; k++) begin
        vectors++;
        if (rd_data[k*DW +: DW] !== exp_data(k) || rd_busy[k] !== exp_busy(k)) begin
          miscompares++;
          $display("FAIL random_read n%0d port%0d: got %h busy %b want %h busy %b",
                   n, k, rd_data[k*DW +: DW], rd_busy[k], exp_data(k), exp_busy(k));
        end
      end
      vectors++;
      if (busy_count !== exp_count()) begin
        miscompares++; $display("FAIL random_count n%0d: got %0d want %0d", n, busy_count, exp_count());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    model_clear();
    idle();
    rd_addr = '0;
    test_reset();
    test_dual_write();
    test_x0();
    test_scoreboard();
    test_rsv_and_write();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
